// File: rtl/sync_frame_transmitter.sv
// Source end of the "1011" sync-marker serial link: sends the marker, then the
// payload MSB-first, stuffing a 0 after every "101" so the marker stays unique.
module sync_frame_transmitter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  sequence_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [3:0] SyncMarker = 4'b1011;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, STUFF} state_t;

  // state_q names the kind of bit currently on the line.
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [1:0]            syncIdx_q, syncIdx_d;
  logic [2:0]            hist_q, hist_d;
  logic                  seq_q, seq_d;
  logic                  done_q, done_d;
  logic                  emitData;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    syncIdx_d = syncIdx_q;
    hist_d    = hist_q;
    seq_d     = 1'b0;
    done_d    = 1'b0;
    emitData  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SYNC;
          shift_d   = data_in;
          bitCnt_d  = '0;
          syncIdx_d = 2'd0;
          seq_d     = SyncMarker[3];
          hist_d    = {hist_q[1:0], SyncMarker[3]};
        end
      end
      SYNC: begin
        if (syncIdx_q != 2'd3) begin
          // Marker bit k (sent k-th) lives at SyncMarker[3-k], i.e. index ~k.
          syncIdx_d = syncIdx_q + 2'd1;
          seq_d     = SyncMarker[~syncIdx_d];
          hist_d    = {hist_q[1:0], SyncMarker[~syncIdx_d]};
        end else begin
          emitData = 1'b1;
        end
      end
      DATA: begin
        if (bitCnt_q == CNT_W'(DATA_WIDTH)) begin
          state_d = IDLE;
        end else if (hist_q == 3'b101) begin
          state_d = STUFF;
          hist_d  = {hist_q[1:0], 1'b0};
        end else begin
          emitData = 1'b1;
        end
      end
      STUFF: begin
        emitData = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emitData) begin
      state_d  = DATA;
      seq_d    = shift_q[DATA_WIDTH-1];
      shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
      bitCnt_d = bitCnt_q + 1'b1;
      hist_d   = {hist_q[1:0], shift_q[DATA_WIDTH-1]};
      done_d   = (bitCnt_q == CNT_W'(DATA_WIDTH - 1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      syncIdx_q <= 2'd0;
      hist_q    <= 3'b000;
      seq_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      syncIdx_q <= syncIdx_d;
      hist_q    <= hist_d;
      seq_q     <= seq_d;
      done_q    <= done_d;
    end
  end

  assign sequence_out = seq_q;
  assign frame_done   = done_q;
  assign ready        = (state_q == IDLE);
  assign busy         = ~ready;

endmodule

// File: tb/tb_sync_frame_transmitter.sv
// Self-checking bench for sync_frame_transmitter: expected line bits come from a
// queue-based frame builder; a sliding 4-bit window acts as the 1011 detector.
module tb_sync_frame_transmitter;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data_in;
  logic         ready;
  logic         sequence_out;
  logic         busy;
  logic         frame_done;

  int   checks = 0;
  int   errors = 0;
  logic [3:0] lineWin;
  logic detHit;
  bit   expectQ[$];

  always #5 clock = ~clock;

  sync_frame_transmitter #(.DATA_WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .data_in(data_in),
    .ready(ready),
    .sequence_out(sequence_out),
    .busy(busy),
    .frame_done(frame_done)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    lineWin = {lineWin[2:0], sequence_out};
    detHit  = (lineWin == 4'b1011);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " seq"},   W'(sequence_out), W'(1'b0));
    checkOutput({tag, " ready"}, W'(ready),        W'(1'b1));
    checkOutput({tag, " busy"},  W'(busy),         W'(1'b0));
    checkOutput({tag, " done"},  W'(frame_done),   W'(1'b0));
    checkOutput({tag, " det"},   W'(detHit),       W'(1'b0));
  endtask

  // Marker, then each payload bit; a 0 follows any "101" tail except after the last bit.
  function automatic void buildFrame(input logic [W-1:0] d);
    int n;
    expectQ = {1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = W - 1; i >= 0; i--) begin
      expectQ.push_back(d[i]);
      n = expectQ.size();
      if (i > 0 && expectQ[n-3] == 1'b1 && expectQ[n-2] == 1'b0 && expectQ[n-1] == 1'b1)
        expectQ.push_back(1'b0);
    end
  endfunction

  // Called in an idle cycle. mode 0: start low while busy; 1: random start/data while busy; 2: start held high.
  task automatic applyStimulus(input logic [W-1:0] d, input int mode);
    string tag;
    int    last;
    buildFrame(d);
    last    = expectQ.size() - 1;
    start   = 1'b1;
    data_in = d;
    for (int k = 0; k <= last; k++) begin
      tick();
      start   = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom) : 1'b1;
      data_in = W'($urandom);
      tag = $sformatf("d%02h k%0d", d, k);
      checkOutput({tag, " seq"},   W'(sequence_out), W'(expectQ[k]));
      checkOutput({tag, " ready"}, W'(ready),        W'(1'b0));
      checkOutput({tag, " busy"},  W'(busy),         W'(1'b1));
      checkOutput({tag, " done"},  W'(frame_done),   W'(k == last));
      checkOutput({tag, " det"},   W'(detHit),       W'(k == 3));
    end
    tick();
    checkIdle($sformatf("d%02h gap", d));
    start = (mode == 2);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    lineWin = 4'b0000;
    detHit  = 1'b0;

    repeat (3) begin
      tick();
      checkIdle("reset");
    end
    reset = 1'b1;
    repeat (2) begin
      tick();
      checkIdle("post-reset");
    end

    applyStimulus(8'h00, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hB6, 0);
    applyStimulus(8'h05, 0);
    tick();
    checkIdle("extra idle");

    repeat (3) applyStimulus(8'hFF, 2);
    applyStimulus(8'hFF, 1);
    applyStimulus(8'h3C, 1);
    start = 1'b0;

    for (int i = 0; i < 8; i++)
      applyStimulus(W'($urandom), int'($urandom_range(0, 2)));
    start = 1'b0;
    tick();
    checkIdle("random end");

    start   = 1'b1;
    data_in = 8'h00;
    for (int k = 0; k <= 6; k++) begin
      tick();
      start = 1'b0;
    end
    checkOutput("abort pre seq",  W'(sequence_out), W'(1'b0));
    checkOutput("abort pre busy", W'(busy),         W'(1'b1));
    reset = 1'b0;
    #1;
    checkIdle("abort async");
    repeat (2) begin
      tick();
      checkIdle("abort hold");
    end
    reset = 1'b1;
    tick();
    checkIdle("abort release");
    applyStimulus(8'hC3, 0);
    applyStimulus(8'h6D, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
